// File: rtl/fwnoc_tgen_pkg.sv
// fwnoc_tgen_pkg: flit field layout, mode/state encodings, LFSR constants and node-id helper for fwnoc_tgen
package fwnoc_tgen_pkg;
  localparam int FLD_W = 8;
  localparam int IDX_W = 16;
  localparam int HDR_DX_LSB = 0;
  localparam int HDR_DY_LSB = 8;
  localparam int HDR_LEN_LSB = 16;
  localparam int SRC_LSB = 24;
  localparam int PAY_SEQ_LSB = 16;
  localparam int PAY_IDX_LSB = 0;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {MODE_FIXED, MODE_RR, MODE_RAND, MODE_RSVD} mode_e;
  typedef enum logic [1:0] {G_IDLE, G_HDR, G_PAY, G_GAP} gen_state_e;
  typedef enum logic {C_HDR, C_PAY} chk_state_e;
  function automatic int node_id(int x, int y, int y_size);
    return x * y_size + y;
  endfunction
  function automatic logic [15:0] lfsr_next(logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0);
  endfunction
endpackage

// File: rtl/fwnoc_tgen_if.sv
// fwnoc_tgen_if: valid/ready flit channel (dat, valid, ready) with master (sender) and slave (receiver) modports
interface fwnoc_tgen_if #(parameter int DATA_WIDTH = 32) ();
  logic [DATA_WIDTH-1:0] dat;
  logic valid;
  logic ready;
  modport master (output dat, output valid, input ready);
  modport slave (input dat, input valid, output ready);
endinterface

// File: rtl/fwnoc_tgen_chk.sv
// fwnoc_tgen_chk: rx packet checker; ports clock/reset/cfg_rx_throttle in, rx slave channel, rx_pkts/err_cnt out
module fwnoc_tgen_chk
  import fwnoc_tgen_pkg::*;
#(
  parameter int MY_X = 0,
  parameter int MY_Y = 0,
  parameter int CNT_W = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic cfg_rx_throttle,
  fwnoc_tgen_if.slave rx,
  output logic [CNT_W-1:0] rx_pkts,
  output logic [CNT_W-1:0] err_cnt
);
  chk_state_e state, state_nx;
  logic [7:0] src, len, n;
  logic [15:0] exp_idx;
  logic [31:0] d;
  logic [1:0] errs;
  logic fire, last;
  always_comb begin
    d = rx.dat[31:0];
    fire = rx.valid && rx.ready;
    errs = state == C_HDR
      ? 2'(d[HDR_DX_LSB +: FLD_W] != 8'(MY_X) || d[HDR_DY_LSB +: FLD_W] != 8'(MY_Y))
      : 2'(d[SRC_LSB +: FLD_W] != src) + 2'(d[PAY_IDX_LSB +: IDX_W] != exp_idx);
    last = state == C_HDR ? d[HDR_LEN_LSB +: FLD_W] == 8'd0 : n == len - 8'd1;
    state_nx = !fire ? state : last ? C_HDR : C_PAY;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= C_HDR;
      rx.ready <= 1'b0;
      rx_pkts <= '0;
      err_cnt <= '0;
      src <= '0;
      len <= '0;
      n <= '0;
      exp_idx <= '0;
    end else begin
      state <= state_nx;
      rx.ready <= cfg_rx_throttle ? !rx.ready : 1'b1;
      if (fire) begin
        err_cnt <= err_cnt + CNT_W'(errs);
        if (last) rx_pkts <= rx_pkts + 1'b1;
        if (state == C_HDR) begin
          src <= d[SRC_LSB +: FLD_W];
          len <= d[HDR_LEN_LSB +: FLD_W];
          n <= '0;
          exp_idx <= '0;
        end else begin
          n <= n + 8'd1;
          exp_idx <= d[PAY_IDX_LSB +: IDX_W] + 16'd1;
        end
      end
    end
  end
endmodule

// File: rtl/fwnoc_tgen.sv
// fwnoc_tgen: per-node NoC traffic generator+checker; clock/reset/cfg_* in, tx master and rx slave channels, busy and tx/rx/err counters out
module fwnoc_tgen
  import fwnoc_tgen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int X_SIZE = 2,
  parameter int Y_SIZE = 2,
  parameter int MY_X = 0,
  parameter int MY_Y = 0,
  parameter int CNT_W = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic cfg_start,
  input  logic cfg_stop,
  input  logic [1:0] cfg_mode,
  input  logic [7:0] cfg_dst_x,
  input  logic [7:0] cfg_dst_y,
  input  logic [7:0] cfg_len,
  input  logic [7:0] cfg_gap,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic cfg_rx_throttle,
  fwnoc_tgen_if.master tx,
  fwnoc_tgen_if.slave rx,
  output logic busy,
  output logic [CNT_W-1:0] tx_pkts,
  output logic [CNT_W-1:0] rx_pkts,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int N = X_SIZE * Y_SIZE;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [15:0] NK = 16'(N);
  localparam logic [15:0] YK = 16'(Y_SIZE);
  localparam logic [15:0] SELF = 16'(node_id(MY_X, MY_Y, Y_SIZE));
  localparam logic [7:0] SRC = 8'(node_id(MY_X, MY_Y, Y_SIZE));
  gen_state_e state, state_nx;
  logic [7:0] dst_x, dst_y, len, idx, gap_cnt, nx_x, nx_y;
  logic [15:0] lfsr, rr_idx, rr_inc, rr_nx, k_rr, k_rnd, k;
  logic [CNT_W-1:0] run_cnt;
  logic [31:0] w;
  logic stop_q, fire, done, run_end, enter_hdr, halt;
  always_comb begin
    fire = tx.valid && tx.ready;
    done = fire && (state == G_HDR ? len == 8'd0 : idx == len - 8'd1);
    halt = stop_q || cfg_stop;
    run_end = halt || (cfg_count != '0 && run_cnt + 1'b1 == cfg_count);
    rr_inc = rr_idx + 16'd1 == NK ? 16'd0 : rr_idx + 16'd1;
    k_rr = rr_idx == SELF ? rr_inc : rr_idx;
    rr_nx = k_rr + 16'd1 == NK ? 16'd0 : k_rr + 16'd1;
    k_rnd = 16'(lfsr[IW-1:0]);
    k_rnd = k_rnd >= NK ? k_rnd - NK : k_rnd;
    k = cfg_mode == MODE_RR ? k_rr : k_rnd;
    nx_x = cfg_mode == MODE_RR || cfg_mode == MODE_RAND ? 8'(k / YK) : cfg_dst_x;
    nx_y = cfg_mode == MODE_RR || cfg_mode == MODE_RAND ? 8'(k % YK) : cfg_dst_y;
    state_nx = state;
    enter_hdr = 1'b0;
    case (state)
      G_IDLE: begin
        enter_hdr = cfg_start && !cfg_stop;
        state_nx = enter_hdr ? G_HDR : G_IDLE;
      end
      G_GAP: begin
        enter_hdr = !halt && gap_cnt == 8'd1;
        state_nx = halt ? G_IDLE : enter_hdr ? G_HDR : G_GAP;
      end
      default: begin
        enter_hdr = done && !run_end && cfg_gap == 8'd0;
        state_nx = done ? (run_end ? G_IDLE : cfg_gap != 8'd0 ? G_GAP : G_HDR)
                 : fire ? G_PAY : state;
      end
    endcase
    w = '0;
    if (state == G_HDR) begin
      w[HDR_DX_LSB +: FLD_W] = dst_x;
      w[HDR_DY_LSB +: FLD_W] = dst_y;
      w[HDR_LEN_LSB +: FLD_W] = len;
      w[SRC_LSB +: FLD_W] = SRC;
    end else if (state == G_PAY) begin
      w[PAY_IDX_LSB +: IDX_W] = 16'(idx);
      w[PAY_SEQ_LSB +: FLD_W] = tx_pkts[7:0];
      w[SRC_LSB +: FLD_W] = SRC;
    end
  end
  assign tx.dat = DATA_WIDTH'(w);
  assign tx.valid = state == G_HDR || state == G_PAY;
  assign busy = state != G_IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= G_IDLE;
      lfsr <= LFSR_SEED;
      rr_idx <= '0;
      tx_pkts <= '0;
      run_cnt <= '0;
      stop_q <= 1'b0;
      dst_x <= '0;
      dst_y <= '0;
      len <= '0;
      idx <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_nx;
      stop_q <= state_nx != G_IDLE && halt;
      run_cnt <= state == G_IDLE ? '0 : done ? run_cnt + 1'b1 : run_cnt;
      if (done) tx_pkts <= tx_pkts + 1'b1;
      idx <= state == G_HDR ? '0 : fire ? idx + 8'd1 : idx;
      gap_cnt <= done ? cfg_gap : state == G_GAP ? gap_cnt - 8'd1 : gap_cnt;
      if (enter_hdr) begin
        dst_x <= nx_x;
        dst_y <= nx_y;
        len <= cfg_len;
        lfsr <= lfsr_next(lfsr);
        if (cfg_mode == MODE_RR) rr_idx <= rr_nx;
      end
    end
  end
  fwnoc_tgen_chk #(.MY_X(MY_X), .MY_Y(MY_Y), .CNT_W(CNT_W)) u_chk (
    .clock(clock),
    .reset(reset),
    .cfg_rx_throttle(cfg_rx_throttle),
    .rx(rx),
    .rx_pkts(rx_pkts),
    .err_cnt(err_cnt)
  );
endmodule

// File: doc/fwnoc_tgen.md
Name: fwnoc_tgen

Overview:
- Synthesisable per-node traffic generator and checker for fwnoc meshes of any X_SIZE x Y_SIZE.
- One instance attaches to each node's ingress port (tx side) and egress port (rx side).
- Replaces per-port rv_data_out/in BFMs for scalable stress runs: it generates addressed packets in fixed, round-robin or LFSR-random destination modes with programmable length, gap and rx backpressure.
- It checks every received packet and keeps counters.

Parameters:
- DATA_WIDTH, 32, flit width; must be >= 32; bits above 31 are driven 0 and ignored.
- X_SIZE, 2, mesh width.
- Y_SIZE, 2, mesh height.
- MY_X, 0, this node's X coordinate.
- MY_Y, 0, this node's Y coordinate.
- CNT_W, 32, width of the packet and error counters.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cfg_start  in  1  pulse; begins a run when the generator is in IDLE.
- cfg_stop  in  1  pulse; ends the run after the current packet completes.
- cfg_mode  in  2  0 = fixed, 1 = round-robin, 2 = random, 3 = reserved (treated as fixed).
- cfg_dst_x  in  8  fixed-mode destination X.
- cfg_dst_y  in  8  fixed-mode destination Y.
- cfg_len  in  8  payload flits per packet; 0 = header-only.
- cfg_gap  in  8  idle cycles between packets.
- cfg_count  in  CNT_W  packets per run; 0 = unlimited.
- cfg_rx_throttle  in  1  when 1, rx_ready toggles every cycle.
- tx_dat  out  DATA_WIDTH  flit to the NoC.
- tx_valid  out  1  tx flit valid.
- tx_ready  in  1  NoC accepts the flit.
- rx_dat  in  DATA_WIDTH  flit from the NoC.
- rx_valid  in  1  rx flit valid.
- rx_ready  out  1  checker accepts the flit.
- busy  out  1  generator not in IDLE.
- tx_pkts  out  CNT_W  packets fully sent.
- rx_pkts  out  CNT_W  packets fully received.
- err_cnt  out  CNT_W  check failures.

Behaviour:
- Reset values: tx_valid=0, tx_dat=0, rx_ready=0, busy=0, all counters 0, LFSR=16'hACE1, rr index=0, both FSMs idle.
- rx_ready goes to 1 on the first cycle after reset.
- Transfer rule: a flit transfers when valid && ready are high on the same rising edge.
  - tx_dat and tx_valid are held stable while tx_valid && !tx_ready.
  - tx_valid never drops without a transfer.
- Flit formats:
  - Header: [7:0] dst_x, [15:8] dst_y, [23:16] len, [31:24] src id.
  - Payload: [31:24] src id, [23:16] pkt_seq, [15:0] flit index 0..len-1.
  - src id = MY_X*Y_SIZE+MY_Y. pkt_seq = tx_pkts[7:0] at the header.
- Generator FSM: IDLE -> HDR -> PAY -> GAP -> HDR ... -> IDLE.
  - IDLE: cfg_start seen -> HDR. tx_valid rises the next cycle (1-cycle latency).
  - HDR: on transfer -> PAY if len!=0. Otherwise the packet is done.
  - PAY: on the transfer of flit len-1 the packet is done.
  - Packet done: tx_pkts++. Then:
    - -> IDLE if the run count is reached or a stop is pending.
    - -> GAP if cfg_gap!=0.
    - -> HDR otherwise.
  - GAP: counts cfg_gap cycles, then -> HDR.
  - cfg_len and the destination are latched on entry to HDR. Config changes mid-packet have no effect on that packet.
  - cfg_stop is latched as pending in any non-IDLE state. cfg_start outside IDLE is ignored. Simultaneous start+stop in IDLE starts no run.
- Destination selection:
  - fixed: cfg_dst_x/cfg_dst_y.
  - round-robin: node index k = x*Y_SIZE+y. k advances per packet, skipping own id, wrapping at N=X_SIZE*Y_SIZE. When N=1 it sends to self.
  - random: LFSR x^16+x^14+x^13+x^11 steps once per header. k = lfsr[IW-1:0], where IW = clog2(N). If k >= N, k -= N. Self is allowed.
- Checker FSM: C_HDR -> C_PAY (len!=0) -> C_HDR.
  - Header check: dst_x==MY_X and dst_y==MY_Y; a mismatch counts 1 error.
  - Payload check: src id must equal the header src and the index must equal the expected count; each mismatch counts 1 error. The expected count then resyncs to received index+1.
  - rx_pkts++ on the last flit.
- Counters wrap at 2^CNT_W. The error increment and the rx_pkts increment on the same flit both take effect.
- Reset mid-packet aborts both FSMs immediately. A partial packet is not counted.

Decomposition:
- Package fwnoc_tgen_pkg holds:
  - header and payload field offsets and widths;
  - mode encodings;
  - the LFSR seed and taps;
  - a node-id function (x,y) -> x*Y_SIZE+y.
- One sub-module, fwnoc_tgen_chk, holds the checker FSM, rx_ready throttle, rx_pkts and err_cnt. The generator stays in the top.

Test Plan:
- Loopback, fixed mode, MY=(0,0), dst=(0,0), len=3, gap=0, count=2, tx looped to rx:
  - tx flits: 0x00030000, 0x00000000, 0x00000001, 0x00000002, then a header for packet seq 1.
  - End state: tx_pkts=2, rx_pkts=2, err_cnt=0, busy=0.
- Backpressure: tx_ready low for 5 cycles mid-payload -> tx_dat/tx_valid stable throughout, no flit lost or duplicated.
- 2x2 fwnoc, all four nodes in round-robin mode, count=6, len=4, cfg_rx_throttle=1:
  - each node sends 2 packets to each other node;
  - each rx_pkts=6, err_cnt=0 everywhere.
- Error injection: header with dst_y=1 into node (0,0), then a payload with index 2 where 0 is expected -> err_cnt=2, rx_pkts=1.
- cfg_stop during packet 1 of an unlimited run with len=8 -> packet completes, tx_pkts=2, busy=0, no further tx_valid.
- Reset asserted mid-payload -> next cycle tx_valid=0, counters 0, LFSR=0xACE1; a fresh run then proceeds cleanly.
